// File: rtl/switch_cleanup.sv
// Switch/button cleanup: 2-flop synchronizer, debounce FSM, press pulse and
// optional auto-repeat pulses while the switch stays held.
module switch_cleanup #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned HOLD_CYCLES     = 2500000,
   parameter int unsigned REPEAT_CYCLES   = 500000,
   parameter bit          REPEAT_EN       = 1'b1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rawIn,
   output logic       level,
   output logic       pulse,
   output logic [1:0] state
);

   localparam int unsigned RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned RW   = $clog2(RMAX);

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_WAIT_HI = 2'b01,
      S_HELD    = 2'b10,
      S_WAIT_LO = 2'b11
   } state_t;

   logic [1:0]    r_sync;
   state_t        r_state;
   logic [DW-1:0] r_dcount;
   logic [RW-1:0] r_rcount;
   logic          r_use_rep;
   logic          r_level;
   logic          r_pulse;

   logic          w_sync_in;
   logic [RW-1:0] w_rlast;

   assign w_sync_in = r_sync[1];
   // Repeat target is a select between the hold delay and the repeat interval.
   assign w_rlast   = r_use_rep ? REP_LAST : HOLD_LAST;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync    <= 2'b00;
         r_state   <= S_IDLE;
         r_dcount  <= '0;
         r_rcount  <= '0;
         r_use_rep <= 1'b0;
         r_level   <= 1'b0;
         r_pulse   <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], rawIn};
         r_pulse <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_sync_in) begin
                  r_state  <= S_WAIT_HI;
                  r_dcount <= '0;
               end
            end
            S_WAIT_HI: begin
               if (!w_sync_in) begin
                  r_state <= S_IDLE;
               end else if (r_dcount == DEB_LAST) begin
                  r_state   <= S_HELD;
                  r_level   <= 1'b1;
                  r_pulse   <= 1'b1;
                  r_rcount  <= '0;
                  r_use_rep <= 1'b0;
               end else begin
                  r_dcount <= r_dcount + DW'(1);
               end
            end
            S_HELD: begin
               if (!w_sync_in) begin
                  r_state  <= S_WAIT_LO;
                  r_dcount <= '0;
               end else if (REPEAT_EN) begin
                  if (r_rcount == w_rlast) begin
                     r_pulse   <= 1'b1;
                     r_rcount  <= '0;
                     r_use_rep <= 1'b1;
                  end else begin
                     r_rcount <= r_rcount + RW'(1);
                  end
               end
            end
            S_WAIT_LO: begin
               // A bounce back high restarts the full hold delay.
               if (w_sync_in) begin
                  r_state   <= S_HELD;
                  r_rcount  <= '0;
                  r_use_rep <= 1'b0;
               end else if (r_dcount == DEB_LAST) begin
                  r_state <= S_IDLE;
                  r_level <= 1'b0;
               end else begin
                  r_dcount <= r_dcount + DW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign level = r_level;
   assign pulse = r_pulse;
   assign state = 2'(r_state);

endmodule

// File: doc/switch_cleanup.md
SWITCH_CLEANUP -- requirements
Module: switch_cleanup

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rstn.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the stable-input time in clk cycles (10 ms at 5 MHz); minimum 2.
REQ-003 Parameter HOLD_CYCLES, default 2500000, SHALL set the delay from press pulse to first auto-repeat pulse (500 ms); minimum 2.
REQ-004 Parameter REPEAT_CYCLES, default 500000, SHALL set the interval between later auto-repeat pulses (100 ms); minimum 2.
REQ-005 Parameter REPEAT_EN, default 1, SHALL enable auto-repeat when 1; when 0, HELD produces no pulses.
REQ-006 Port clk, input, 1 bit, SHALL be the 5 MHz system clock; all flops are rising-edge.
REQ-007 Port rstn, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-008 Port rawIn, input, 1 bit, SHALL be the asynchronous, bouncy switch or button level, active high.
REQ-009 Port level, output, 1 bit, SHALL be the registered debounced level.
REQ-010 Port pulse, output, 1 bit, SHALL be a registered single-cycle strobe for press and auto-repeat events; it drives the counter up or dn input.
REQ-011 Port state, output, 2 bits, SHALL expose the FSM state for oscilloscope viewing: IDLE=00, WAIT_HI=01, HELD=10, WAIT_LO=11.

Function
REQ-012 rawIn SHALL pass through a 2-flop synchronizer; syncIn (the second stage) is the only signal the FSM uses.
REQ-013 A debounce counter (dcount) SHALL be sized to hold DEBOUNCE_CYCLES-1, and a repeat counter (rcount) to hold max(HOLD_CYCLES, REPEAT_CYCLES)-1; neither counter shall wrap.
REQ-014 In IDLE, if syncIn=1: go to WAIT_HI with dcount=0; otherwise stay in IDLE.
REQ-015 In WAIT_HI, if syncIn=0: return to IDLE, reject the glitch, and produce no pulse.
REQ-016 In WAIT_HI, if syncIn=1 and dcount<DEBOUNCE_CYCLES-1: increment dcount.
REQ-017 In WAIT_HI, if syncIn=1 and dcount=DEBOUNCE_CYCLES-1: go to HELD, set level=1, set pulse=1 for exactly one cycle, set rcount=0, and load the repeat target with HOLD_CYCLES.
REQ-018 Press latency SHALL be exactly DEBOUNCE_CYCLES+2 clk edges, counted from the first edge that samples rawIn=1 to the edge that sets pulse.
REQ-019 In HELD, if syncIn=0: go to WAIT_LO with dcount=0; level stays 1 and no pulse is produced.
REQ-020 In HELD with REPEAT_EN=1, rcount SHALL increment each cycle; at rcount=target-1 it SHALL set pulse=1 for one cycle, clear rcount and load the target with REPEAT_CYCLES.
REQ-021 In WAIT_LO, no pulse SHALL be produced and rcount SHALL be held.
REQ-022 In WAIT_LO, if syncIn=1: return to HELD, clear rcount and reload the target with HOLD_CYCLES (release-bounce restarts the hold delay).
REQ-023 In WAIT_LO, if syncIn=0 and dcount=DEBOUNCE_CYCLES-1: go to IDLE and set level=0; there is no release pulse.
REQ-024 pulse SHALL never be high on two consecutive cycles.
REQ-025 level SHALL change only on the WAIT_HI->HELD and WAIT_LO->IDLE transitions.

Reset
REQ-026 While rstn=0, all flops SHALL clear asynchronously: synchronizer=0, state=IDLE, dcount=0, rcount=0, level=0, pulse=0.
REQ-027 On rstn release, flops SHALL update on the first clk edge after release; the reset-release synchronizer lives in the clock/reset generator, not in this block.
REQ-028 If rawIn is held high through reset release, the block SHALL perform a full debounce and then produce one press pulse, never an immediate pulse.
REQ-029 Reset asserted mid-operation, in any state, SHALL abort the operation with no pulse emitted during or after assertion.

Verification (DEBOUNCE=4, HOLD=10, REPEAT=5, REPEAT_EN=1 unless stated)
REQ-030 Clean press: rawIn 0->1 held for 30 cycles -> pulse high on cycle 6 only, level=1 from cycle 6, repeat pulses at cycles 16, 21 and 26; rawIn->0 -> level=0 six edges later with no pulse.
REQ-031 Bounce: rawIn toggles 1,0,1,1,0 at one-cycle steps then holds 1 -> exactly one pulse, occurring DEBOUNCE_CYCLES+2 edges after the final 0->1.
REQ-032 Glitch: rawIn high for 3 cycles, then low -> state visits WAIT_HI and returns to IDLE; pulse and level stay 0.
REQ-033 Release bounce: in HELD, rawIn drops for 2 cycles then returns to 1 -> level stays 1, no pulse, and the next repeat pulse occurs 10 cycles after re-entry to HELD.
REQ-034 REPEAT_EN=0: hold rawIn for 40 cycles -> exactly one pulse.
REQ-035 Reset: assert rstn=0 in HELD -> level, pulse and state go to 0 immediately without waiting for a clk edge; release with rawIn=1 -> pulse 6 edges after release.
